// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues in-order instruction-memory requests for the current PC and pairs
// the returning words with their PCs in a small FIFO toward decode. Flush squashes all in-flight work.
module instr_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic        pc_advance,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    // Tag queue: one slot per outstanding request, in issue order.
    logic [31:0]      tag_pc [DEPTH];
    logic [DEPTH-1:0] tag_live;
    logic [AW-1:0]    tag_wr;
    logic [AW-1:0]    tag_rd;
    logic [CW-1:0]    tag_cnt;

    // Output FIFO toward decode.
    entry_t           fifo_mem [DEPTH];
    logic [AW-1:0]    fifo_wr;
    logic [AW-1:0]    fifo_rd;
    logic [CW-1:0]    fifo_cnt;

    logic [CW:0]      in_use;
    logic             credit_ok;
    logic             accept;
    logic             resp_pop;
    logic             resp_fwd;
    logic             id_pop;

    // A slot is either waiting on memory or holding a word for decode; both count against DEPTH.
    assign in_use    = {1'b0, tag_cnt} + {1'b0, fifo_cnt};
    assign credit_ok = in_use < (CW+1)'(DEPTH);

    assign imem_req   = rst && !flush && credit_ok;
    assign imem_addr  = pc_in;
    assign accept     = imem_req && imem_gnt;
    assign pc_advance = accept;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp_pop = imem_rvalid && (tag_cnt != '0);
    assign resp_fwd = resp_pop && tag_live[tag_rd] && !flush;
    assign id_pop   = id_valid && id_ready && !flush;

    assign id_valid = (fifo_cnt != '0);
    assign id_pc    = id_valid ? fifo_mem[fifo_rd].pc    : RESET_PC;
    assign id_instr = id_valid ? fifo_mem[fifo_rd].instr : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr   <= '0;
            tag_rd   <= '0;
            tag_cnt  <= '0;
            tag_live <= '0;
        end else begin
            if (accept)
                tag_wr <= tag_wr + PTR_ONE;
            if (resp_pop)
                tag_rd <= tag_rd + PTR_ONE;

            case ({accept, resp_pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_ONE;
                2'b01:   tag_cnt <= tag_cnt - CNT_ONE;
                default: tag_cnt <= tag_cnt;
            endcase

            // Flush kills responses still in flight; accept is blocked in that cycle.
            if (flush)
                tag_live <= '0;
            else if (accept)
                tag_live[tag_wr] <= 1'b1;
        end
    end

    // NOTE: storage arrays carry no reset; the counters and live bits decide which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept)
            tag_pc[tag_wr] <= pc_in;
        if (resp_fwd)
            fifo_mem[fifo_wr] <= '{pc: tag_pc[tag_rd], instr: imem_rdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else if (flush) begin
            fifo_wr  <= '0;
            fifo_rd  <= '0;
            fifo_cnt <= '0;
        end else begin
            if (resp_fwd)
                fifo_wr <= fifo_wr + PTR_ONE;
            if (id_pop)
                fifo_rd <= fifo_rd + PTR_ONE;

            case ({resp_fwd, id_pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue: a queue-based model of the tag and output
// queues plus a memory responder with variable grant and response latency.
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_advance (pc_advance),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc)
    );

    typedef struct packed { logic live; logic [31:0] pc; }   tag_t;
    typedef struct packed { logic [31:0] pc; logic [31:0] instr; } ent_t;
    typedef struct packed { logic [31:0] pc; int due; }      pend_t;

    tag_t  tq[$];   // requests accepted, response not yet seen
    ent_t  fq[$];   // words waiting for decode
    pend_t pq[$];   // memory side: responses still to be returned

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int delivered;
    int adv_seen;
    logic [31:0] pc;

    int          g_gnt = 100;
    int          g_lat_lo = 1;
    int          g_lat_hi = 1;
    int          g_rdy = 100;
    int          g_flush = 0;
    logic [31:0] g_target = 32'h0;
    bit          g_rand_target = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive_cycle();
        pc_in    = pc;
        imem_gnt = ($urandom_range(99) < g_gnt);
        id_ready = ($urandom_range(99) < g_rdy);
        flush    = ($urandom_range(99) < g_flush);
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pq[0].pc);
        end else if (pq.size() == 0 && $urandom_range(19) == 0) begin
            imem_rvalid = 1'b1;           // stray response with nothing outstanding
            imem_rdata  = $urandom;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
    endtask

    task automatic tick();
        logic        exp_req, exp_adv, exp_valid;
        logic [31:0] exp_pc, exp_instr;
        tag_t        t;
        #2;
        exp_req   = !flush && (tq.size() + fq.size() < DEPTH);
        exp_adv   = exp_req && imem_gnt;
        exp_valid = (fq.size() != 0);
        exp_pc    = exp_valid ? fq[0].pc    : RESET_PC;
        exp_instr = exp_valid ? fq[0].instr : 32'h0;
        check("imem_req",   imem_req,   exp_req);
        check("pc_advance", pc_advance, exp_adv);
        check("imem_addr",  imem_addr,  pc);
        check("id_valid",   id_valid,   exp_valid);
        check("id_pc",      id_pc,      exp_pc);
        check("id_instr",   id_instr,   exp_instr);
        if (pc_advance) adv_seen++;

        @(posedge clk);
        if (exp_valid && id_ready && !flush) begin
            void'(fq.pop_front());
            delivered++;
        end
        if (imem_rvalid && tq.size() > 0) begin
            t = tq.pop_front();
            if (t.live && !flush) fq.push_back('{pc: t.pc, instr: imem_rdata});
        end
        if (flush) begin
            fq.delete();
            foreach (tq[i]) tq[i].live = 1'b0;
        end
        if (exp_adv) tq.push_back('{live: 1'b1, pc: pc_in});
        if (imem_rvalid && pq.size() > 0) void'(pq.pop_front());
        if (exp_adv) pq.push_back('{pc: pc_in, due: cyc + int'($urandom_range(g_lat_hi, g_lat_lo))});
        if (flush)        pc = g_rand_target ? ($urandom & ~32'h3) : g_target;
        else if (exp_adv) pc = pc + 32'h4;
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive_cycle();
            tick();
        end
    endtask

    task automatic set_stream();
        g_gnt = 100; g_lat_lo = 1; g_lat_hi = 1; g_rdy = 100; g_flush = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; pc_in = '0; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
        imem_rdata = '0; id_ready = 1'b0; pc = '0;
        #1;
        check("rst_req",      imem_req,   1'b0);
        check("rst_adv",      pc_advance, 1'b0);
        check("rst_valid",    id_valid,   1'b0);
        check("rst_pc",       id_pc,      RESET_PC);
        check("rst_instr",    id_instr,   32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Stream: one instruction per cycle after a two-cycle fill.
        set_stream();
        pc = 32'h0;
        delivered = 0;
        run(20);
        check("stream_cnt", delivered, 18);

        // Backpressure: exactly DEPTH accepts, then resume once decode drains.
        g_gnt = 0; run(5);
        g_gnt = 100; g_rdy = 0; adv_seen = 0;
        run(10);
        check("bp_accepts", adv_seen, DEPTH);
        g_rdy = 100;
        drive_cycle(); #1; check("bp_first_req", imem_req, 1'b0); tick();
        drive_cycle(); #1; check("bp_resume_req", imem_req, 1'b1); tick();
        run(10);

        // Flush with two requests in flight; their late responses must vanish.
        g_gnt = 0; run(8);
        pc = 32'h10; g_gnt = 100; g_lat_lo = 6; g_lat_hi = 6;
        run(2);
        g_flush = 100; g_rand_target = 1'b0; g_target = 32'h80;
        run(1);
        g_flush = 0; g_gnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(); #1; check("t3_no_valid", id_valid, 1'b0); tick();
        end
        g_gnt = 100; g_lat_lo = 1; g_lat_hi = 1;
        drive_cycle(); #1;
        check("t3_req",  imem_req,  1'b1);
        check("t3_addr", imem_addr, 32'h80);
        tick();
        run(5);

        // Flush coinciding with a response and a decode pop.
        set_stream(); run(5);
        g_flush = 100; g_target = 32'h100;
        drive_cycle(); #1;
        check("t4_valid_before", id_valid, 1'b1);
        check("t4_req", imem_req, 1'b0);
        tick();
        g_flush = 0;
        drive_cycle(); #1;
        check("t4_empty", id_valid, 1'b0);
        check("t4_req_back", imem_req, 1'b1);
        tick();

        // Random grant stalls, response latency, backpressure and redirects.
        g_gnt = 60; g_lat_lo = 1; g_lat_hi = 4; g_rdy = 70; g_flush = 3; g_rand_target = 1'b1;
        run(600);
        g_flush = 0; g_gnt = 0; g_rdy = 100;
        run(10);

        // Asynchronous reset between edges during a burst.
        set_stream(); pc = 32'h40;
        run(6);
        #3 rst = 1'b0;
        #1;
        check("arst_req",   imem_req,   1'b0);
        check("arst_adv",   pc_advance, 1'b0);
        check("arst_valid", id_valid,   1'b0);
        check("arst_pc",    id_pc,      RESET_PC);
        check("arst_instr", id_instr,   32'h0);
        tq.delete(); fq.delete(); pq.delete();
        pc = 32'h200;
        imem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        delivered = 0;
        run(12);
        check("arst_restart", delivered, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
